// File: rtl/urm_echo_timer_pkg.sv
// urm_echo_timer_pkg
//   Shared definitions for the HC-SR04 echo timer and its neighbours:
//   the FSM state encoding and the default timing constants for a 50 MHz
//   board clock. A DistanceCm value of all ones (DIST_SAT) means "no valid
//   distance". The display stage relies on that value as well.
//   Ports: none (package).
package urm_echo_timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOW  = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } urm_state_t;

  localparam int DEF_CLK_DIV         = 50;
  localparam int DEF_US_PER_CM       = 58;
  localparam int DEF_RISE_TIMEOUT_US = 2000;
  localparam int DEF_MAX_ECHO_US     = 25000;
  localparam int DEF_US_W            = 15;
  localparam int DEF_DIST_W          = 9;

  // DIST_SAT at the default distance width. Other widths use '1.
  localparam logic [DEF_DIST_W-1:0] DIST_SAT = '1;

endpackage

// File: rtl/urm_echo_timer_us_tick_gen.sv
// us_tick_gen
//   Produces a one-cycle clock-enable pulse once every CLK_DIV clocks.
//   It does not generate a derived clock. Clear restarts the phase, so the
//   first Tick after a Clear comes exactly CLK_DIV cycles later.
//   Ports:
//     Clock - board clock
//     Reset - synchronous, active-high
//     Clear - restart the tick phase (count back to 0)
//     Tick  - high in the cycle where the count equals CLK_DIV-1
module us_tick_gen
  import urm_echo_timer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count <= '0;
    end else if (count == CW'(CLK_DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign Tick = (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/urm_echo_timer.sv
// urm_echo_timer
//   Measures the width of the HC-SR04 Echo pulse after each Start. The
//   width is reported in whole microseconds and in whole centimetres. A
//   missing echo or an overlong echo is flagged as a timeout.
//   Ports:
//     Clock      - 50 MHz board clock
//     Reset      - synchronous, active-high
//     Start      - one-cycle pulse; arms a measurement (accepted in IDLE only)
//     Echo       - raw asynchronous Echo pin
//     Busy       - high from an accepted Start until Valid
//     Valid      - one-cycle strobe; the result outputs were just updated
//     Timeout    - qualifies the last result: no echo or overlong echo
//     DistanceCm - floor(EchoUs / US_PER_CM), all ones on timeout
//     EchoUs     - Echo high time in whole microseconds
module urm_echo_timer
  import urm_echo_timer_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int US_PER_CM       = DEF_US_PER_CM,
  parameter int RISE_TIMEOUT_US = DEF_RISE_TIMEOUT_US,
  parameter int MAX_ECHO_US     = DEF_MAX_ECHO_US,
  parameter int US_W            = DEF_US_W,
  parameter int DIST_W          = DEF_DIST_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Echo,
  output logic              Busy,
  output logic              Valid,
  output logic              Timeout,
  output logic [DIST_W-1:0] DistanceCm,
  output logic [US_W-1:0]   EchoUs
);

  localparam int SUB_W  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int RISE_W = $clog2(RISE_TIMEOUT_US + 1);

  urm_state_t        state;
  logic              echo_meta, echo_sync, echo_prev;
  logic              echo_rise, echo_fall;
  logic              tick, tick_clear;
  logic [US_W-1:0]   us_cnt, meas_us;
  logic [SUB_W-1:0]  sub_cnt, meas_sub;
  logic [DIST_W-1:0] cm_cnt, meas_cm;
  logic [RISE_W-1:0] rise_cnt;
  logic              sub_wrap, rise_expired;

  // Two-flop synchronizer plus one extra stage for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= Echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  assign echo_rise = echo_sync & ~echo_prev;
  assign echo_fall = ~echo_sync & echo_prev;

  // The tick phase restarts on entry to WAIT_RISE and again at the detected
  // rising edge, so the microsecond count lines up with the start of the echo.
  assign tick_clear = ((state == WAIT_LOW) && !echo_sync) ||
                      ((state == WAIT_RISE) && echo_rise);

  us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (tick_clear),
    .Tick  (tick)
  );

  // Next counter values in MEASURE. A tick in the same cycle as the falling
  // edge is included in the result. The centimetre count comes from a modulo
  // US_PER_CM sub-counter instead of a divider, and it saturates at all ones.
  assign sub_wrap = (sub_cnt == SUB_W'(US_PER_CM - 1));
  assign meas_us  = tick ? us_cnt + 1'b1 : us_cnt;
  assign meas_sub = !tick ? sub_cnt : (sub_wrap ? '0 : sub_cnt + 1'b1);
  assign meas_cm  = (tick && sub_wrap && (cm_cnt != '1)) ? cm_cnt + 1'b1 : cm_cnt;

  assign rise_expired = tick && (rise_cnt == RISE_W'(RISE_TIMEOUT_US - 1));

  // Main FSM. The result outputs load when the FSM enters DONE. Valid is
  // high only for the single DONE cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Valid      <= 1'b0;
      Timeout    <= 1'b0;
      DistanceCm <= '0;
      EchoUs     <= '0;
      us_cnt     <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
      rise_cnt   <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          us_cnt   <= '0;
          sub_cnt  <= '0;
          cm_cnt   <= '0;
          rise_cnt <= '0;
          if (Start) begin
            state <= WAIT_LOW;
            Busy  <= 1'b1;
          end
        end
        WAIT_LOW, WAIT_RISE: begin
          if (state == WAIT_RISE && echo_rise) begin
            state <= MEASURE;
          end else if (rise_expired) begin
            state      <= DONE;
            Valid      <= 1'b1;
            Busy       <= 1'b0;
            Timeout    <= 1'b1;
            EchoUs     <= '0;
            DistanceCm <= '1;
          end else begin
            if (tick) rise_cnt <= rise_cnt + 1'b1;
            if (state == WAIT_LOW && !echo_sync) state <= WAIT_RISE;
          end
        end
        MEASURE: begin
          us_cnt  <= meas_us;
          sub_cnt <= meas_sub;
          cm_cnt  <= meas_cm;
          if (tick && (meas_us == US_W'(MAX_ECHO_US))) begin
            state      <= DONE;
            Valid      <= 1'b1;
            Busy       <= 1'b0;
            Timeout    <= 1'b1;
            EchoUs     <= US_W'(MAX_ECHO_US);
            DistanceCm <= '1;
          end else if (echo_fall) begin
            state      <= DONE;
            Valid      <= 1'b1;
            Busy       <= 1'b0;
            Timeout    <= 1'b0;
            EchoUs     <= meas_us;
            DistanceCm <= meas_cm;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urm_echo_timer.sv
// tb_urm_echo_timer
//   Bench for urm_echo_timer. It uses scaled-down timing so that full
//   timeouts fit in a short run. Stimulus pushes the expected result into a
//   queue, and a separate monitor pops and compares on every Valid.
//   Ports: none (top-level bench).
module tb_urm_echo_timer;

  localparam int CLK_DIV   = 4;
  localparam int US_PER_CM = 5;
  localparam int RISE_TO   = 40;
  localparam int MAX_US    = 300;
  localparam int US_W      = 15;
  localparam int DIST_W    = 5;
  localparam int DIST_SAT  = (1 << DIST_W) - 1;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic              Echo  = 1'b0;
  logic              Busy, Valid, Timeout;
  logic [DIST_W-1:0] DistanceCm;
  logic [US_W-1:0]   EchoUs;

  typedef struct {
    bit timeout;
    int us;
    int cm;
  } result_t;

  result_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      valid_seen = 0;
  longint  cycle = 0;
  longint  valid_cycle = 0;

  urm_echo_timer #(
    .CLK_DIV(CLK_DIV), .US_PER_CM(US_PER_CM), .RISE_TIMEOUT_US(RISE_TO),
    .MAX_ECHO_US(MAX_US), .US_W(US_W), .DIST_W(DIST_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Echo(Echo),
    .Busy(Busy), .Valid(Valid), .Timeout(Timeout),
    .DistanceCm(DistanceCm), .EchoUs(EchoUs)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    @(posedge Clock);
    cycle++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model. An echo held high for N clocks spans floor(N/CLK_DIV)
  // whole microseconds. The distance is that count divided by US_PER_CM and
  // clipped to DIST_SAT. Reaching MAX_US gives a timeout, and so does having
  // no echo at all.
  function automatic result_t model(input bit echo_present, input int high_cycles);
    result_t r;
    int us;
    if (!echo_present) begin
      r.timeout = 1'b1; r.us = 0; r.cm = DIST_SAT;
    end else begin
      us = high_cycles / CLK_DIV;
      if (us >= MAX_US) begin
        r.timeout = 1'b1; r.us = MAX_US; r.cm = DIST_SAT;
      end else begin
        r.timeout = 1'b0; r.us = us;
        r.cm = (us / US_PER_CM > DIST_SAT) ? DIST_SAT : us / US_PER_CM;
      end
    end
    return r;
  endfunction

  // Monitor: every Valid must match the oldest outstanding expectation.
  initial forever begin
    result_t e;
    @(negedge Clock);
    if (Valid) begin
      valid_seen++;
      valid_cycle = cycle;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_valid: got Valid=1 with EchoUs=%0d expected no Valid", EchoUs);
      end else begin
        e = exp_q.pop_front();
        checkOutput("timeout", Timeout, e.timeout);
        checkOutput("echo_us", EchoUs, e.us);
        checkOutput("distance_cm", DistanceCm, e.cm);
        checkOutput("busy_at_valid", Busy, 0);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Runs one full measurement. An optional stale echo is still high at Start.
  // An optional extra Start arrives mid-echo. For a present echo, Echo goes
  // high after `pre` clocks and stays high for exactly `high` clocks.
  task automatic applyStimulus(input bit echo_present, input int pre, input int high,
                               input bit stale, input bit extra_start);
    int     target;
    int     n;
    longint start_cyc;
    target = valid_seen + 1;
    if (stale) begin
      Echo = 1'b1;
      repeat (4) step();
    end
    exp_q.push_back(model(echo_present, high));
    Start = 1'b1;
    start_cyc = cycle + 1;
    step();
    Start = 1'b0;
    if (stale) begin
      repeat ($urandom_range(3, 30)) step();
      Echo = 1'b0;
      repeat ($urandom_range(3, 20)) step();
    end
    if (echo_present) begin
      repeat (pre) step();
      Echo = 1'b1;
      for (int i = 0; i < high; i++) begin
        Start = extra_start && (i == high / 2);
        step();
      end
      Start = 1'b0;
      Echo = 1'b0;
    end
    n = 0;
    while (valid_seen < target && n < 3000) begin
      step();
      n++;
    end
    if (valid_seen < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_wait: got no Valid after %0d cycles expected one", n);
      void'(exp_q.pop_front());
    end else if (!echo_present) begin
      checks++;
      if (valid_cycle - start_cyc < RISE_TO * CLK_DIV - CLK_DIV ||
          valid_cycle - start_cyc > RISE_TO * CLK_DIV + CLK_DIV) begin
        errors++;
        $display("[TB] FAIL rise_timeout_latency: got %0d cycles expected %0d..%0d",
                 valid_cycle - start_cyc, RISE_TO * CLK_DIV - CLK_DIV, RISE_TO * CLK_DIV + CLK_DIV);
      end
    end
    repeat (10) step();
  endtask

  initial begin
    int  high;
    bit  stale;
    bit  extra;

    // Reset held while Echo toggles.
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Echo = ~Echo;
      step();
    end
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_valid", Valid, 0);
    checkOutput("reset_timeout", Timeout, 0);
    checkOutput("reset_distance", DistanceCm, 0);
    checkOutput("reset_echo_us", EchoUs, 0);
    Echo = 1'b0;
    Reset = 1'b0;
    repeat (5) step();

    // Directed cases: nominal values, a cm boundary, no echo, overlong echo,
    // the exact MAX boundary, saturation, and stale echo with an extra Start.
    applyStimulus(1, 20, 100 * CLK_DIV, 0, 0);
    applyStimulus(1, 20, 99 * CLK_DIV + 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 15, 320 * CLK_DIV, 0, 0);
    applyStimulus(1, 15, MAX_US * CLK_DIV, 0, 0);
    applyStimulus(1, 15, (MAX_US - 1) * CLK_DIV + 3, 0, 0);
    applyStimulus(1, 10, 200 * CLK_DIV, 0, 0);
    applyStimulus(1, 10, 50 * CLK_DIV, 1, 1);

    // Reset in mid-measurement. The partial count must never surface.
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (10) step();
    Echo = 1'b1;
    repeat (30 * CLK_DIV) step();
    Reset = 1'b1;
    repeat (2) step();
    Echo = 1'b0;
    step();
    Reset = 1'b0;
    checkOutput("busy_after_reset", Busy, 0);
    repeat (10) step();
    applyStimulus(1, 12, 12 * CLK_DIV, 0, 0);

    // Randomized measurements.
    for (int t = 0; t < 25; t++) begin
      high  = $urandom_range(1, 1400);
      stale = ($urandom_range(0, 3) == 0);
      extra = (high >= 8 && high < 1100 && $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0)
        applyStimulus(0, 0, 0, stale, 0);
      else
        applyStimulus(1, $urandom_range(5, 100), high, stale, extra);
    end

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
